// File: rtl/window_stats_pkg.sv
// Shared types for the windowed statistics consumer.
// Record layout below matches the default DATA_W=8 / WIN=16 build.
package window_stats_pkg;

    localparam int WS_SEQ_W  = 8;
    localparam int WS_DATA_W = 8;
    localparam int WS_WIN    = 16;
    localparam int WS_SUM_W  = WS_DATA_W + $clog2(WS_WIN);

    typedef enum logic {
        WS_FIRST,
        WS_ACCUM
    } ws_state_e;

    typedef struct packed {
        logic [WS_SUM_W-1:0]  sum;
        logic [WS_DATA_W-1:0] min;
        logic [WS_DATA_W-1:0] max;
        logic [WS_DATA_W-1:0] avg;
        logic [WS_SEQ_W-1:0]  seq;
    } ws_rec_t;

endpackage

// File: rtl/window_stats.sv
// Collects WIN samples per window and emits sum/min/max/avg records
// on a valid/ready output with a wrapping window sequence number.
module window_stats
    import window_stats_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WIN    = 16,
    localparam int SUM_W = DATA_W + $clog2(WIN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SUM_W-1:0]    out_sum,
    output logic [DATA_W-1:0]   out_min,
    output logic [DATA_W-1:0]   out_max,
    output logic [DATA_W-1:0]   out_avg,
    output logic [WS_SEQ_W-1:0] out_seq
);

    localparam int LOG_WIN = $clog2(WIN);
    localparam int CNT_W   = LOG_WIN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

    ws_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q;
    logic [SUM_W-1:0]    acc_q;
    logic [DATA_W-1:0]   min_q, max_q;
    logic [WS_SEQ_W-1:0] seq_q;

    logic              accept, last, load, first;
    logic [SUM_W-1:0]  sum_n;
    logic [DATA_W-1:0] min_n, max_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WS_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            clear:           state_d = WS_FIRST;
            accept && last:  state_d = WS_FIRST;
            accept && !last: state_d = WS_ACCUM;
            default:         state_d = state_q;
        endcase
    end

    // Only the completing sample waits on a pending record.
    always_comb begin
        last     = (cnt_q == CNT_LAST);
        in_ready = !clear && !(out_valid && last);
        accept   = in_valid && in_ready;
        load     = accept && last;
        first    = (state_q == WS_FIRST);
    end

    always_comb begin
        sum_n = first ? SUM_W'(in_data) : acc_q + SUM_W'(in_data);
        min_n = (first || in_data < min_q) ? in_data : min_q;
        max_n = (first || in_data > max_q) ? in_data : max_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
            acc_q <= sum_n;
            min_q <= min_n;
            max_q <= max_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_avg   <= '0;
            out_seq   <= '0;
            seq_q     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= sum_n;
            out_min   <= min_n;
            out_max   <= max_n;
            out_avg   <= DATA_W'(sum_n >> LOG_WIN);
            out_seq   <= seq_q;
            seq_q     <= seq_q + WS_SEQ_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
